// File: rtl/uart_loopback.sv
// uart_loopback: 8N1 UART echo. Every correctly framed byte received on
// i_uart_rx is retransmitted, unchanged and in order, on o_uart_tx.
//
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_reset    asynchronous active-high reset
//   i_uart_rx  serial input, asynchronous to i_clk, idle high
//   o_uart_tx  serial output, idle high (registered)
//
// Parameter:
//   CLKS_PER_BIT  clock cycles per bit, must be >= 8
//
// Build option:
//   UART_LOOPBACK_FIFO_EN  defined: 4-entry byte FIFO between RX and TX.
//                          undefined: single holding register + valid flag.
`timescale 1ns/1ps

module uart_loopback #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_uart_rx,
    output logic o_uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic          rx_meta, rx_sync;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_done;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    logic          tx_ready, buf_rd, buf_wr;
    logic          buf_valid, buf_full;
    logic [7:0]    buf_data;

    // Two-flop synchronizer; resets to the idle (high) line level.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver. Samples at mid-bit; leaves STOP at mid-stop-bit so a
    // back-to-back start edge is seen in time.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        // Still low at mid start bit: real frame, else glitch.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        // A low stop bit is a framing error: byte discarded.
                        rx_done  <= rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX can take a byte when idle or on the last cycle of its stop bit,
    // which makes consecutive frames contiguous.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        tx_ready = 1'b0;
        buf_rd   = 1'b0;
        buf_wr   = 1'b0;
        if (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == BIT_LAST))
            tx_ready = 1'b1;
        buf_rd = tx_ready && buf_valid;
        // A full buffer still accepts a byte when it is read the same cycle.
        buf_wr = rx_done && (!buf_full || buf_rd);
    end

    // NOTE: byte storage carries no reset; only the occupancy state
    // (pointers/count or valid flag) is cleared, which is what "empty" means.
`ifdef UART_LOOPBACK_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;

    always_ff @(posedge i_clk) begin
        if (buf_wr) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (buf_wr) wr_ptr <= wr_ptr + 2'd1;
            if (buf_rd) rd_ptr <= rd_ptr + 2'd1;
            case ({buf_wr, buf_rd})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign buf_valid = (fifo_count != 3'd0);
    assign buf_full  = (fifo_count == 3'd4);
    assign buf_data  = fifo_mem[rd_ptr];
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    always_ff @(posedge i_clk) begin
        if (buf_wr) hold_data <= rx_shift;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold_valid <= 1'b0;
        end else if (buf_wr) begin
            hold_valid <= 1'b1;
        end else if (buf_rd) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_valid = hold_valid;
    assign buf_full  = hold_valid;
    assign buf_data  = hold_data;
`endif

    // Transmitter: each of START, DATA0..7, STOP lasts exactly CLKS_PER_BIT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            o_uart_tx <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt    <= '0;
                    o_uart_tx <= 1'b1;
                    if (buf_rd) begin
                        tx_state  <= TX_START;
                        tx_shift  <= buf_data;
                        o_uart_tx <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_idx    <= '0;
                        tx_state  <= TX_DATA;
                        o_uart_tx <= tx_shift[0];
                        tx_shift  <= {1'b1, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state  <= TX_STOP;
                            o_uart_tx <= 1'b1;
                        end else begin
                            tx_idx    <= tx_idx + 3'd1;
                            o_uart_tx <= tx_shift[0];
                            tx_shift  <= {1'b1, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (buf_rd) begin
                            tx_state  <= TX_START;
                            tx_shift  <= buf_data;
                            o_uart_tx <= 1'b0;
                        end else begin
                            tx_state  <= TX_IDLE;
                            o_uart_tx <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    o_uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback.sv
// Self-checking bench for uart_loopback. A serial driver sends frames, a
// line monitor decodes everything seen on o_uart_tx, and a queue of the
// bytes that should come back (well-framed bytes, in order) is the model.
`timescale 1ns/1ps

module tb_uart_loopback;

    localparam int  CPB    = 16;
    localparam real CLK_NS = 40.0;
    localparam real BIT_NS = CPB * CLK_NS;
    localparam int  HALF   = CPB / 2;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
        bit          ok;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tx;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fails  = 0;

    frame_t      got_q[$];
    frame_t      last_q[$];
    logic [7:0]  exp_q[$];

    uart_loopback #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_uart_rx (rx),
        .o_uart_tx (tx)
    );

    always #(CLK_NS / 2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
        rx = 1'b1;
    endtask

    // Waits (bounded) for the expected number of echoes, then lingers long
    // enough that any spurious extra frame would also be decoded.
    task automatic check_echoes(input string tag);
        int budget = (exp_q.size() + 2) * 12 * CPB;
        int n;
        while (got_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        wait_cycles(22 * CPB);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, got_q[i].data, exp_q[i]);
            check({tag, "_framing"}, got_q[i].ok, 1);
        end
        last_q = got_q;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    // Line monitor: start bit detected at offset 0; each bit is sampled at
    // mid-bit and also at its first and last cycle, which must agree, so a
    // wrong bit period breaks the frame.
    initial begin : monitor
        frame_t     f;
        logic [9:0] bits;
        logic [9:0] first;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                f.start = cyc;
                f.ok    = 1'b1;
                f.data  = '0;
                aborted = 1'b0;
                bits    = '0;
                first   = '0;
                for (int k = 1; k < 10 * CPB; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                    if (k % CPB == 1) first[k / CPB] = tx;
                    if (k % CPB == HALF) bits[k / CPB] = tx;
                    if (k % CPB == CPB - 1 && tx !== first[k / CPB]) f.ok = 1'b0;
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
                f.data = bits[8:1];
                if (!aborted) got_q.push_back(f);
            end
        end
    end

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned c0;
        int          lows;
        int          w;
        logic [7:0]  d;
        bit          stop_ok;
        real         bit_ns;
        logic [7:0]  patterns [4];
        logic [7:0]  b2b [3];

        patterns = '{8'hFF, 8'h61, 8'h4A, 8'h32};
        b2b      = '{8'h00, 8'hA5, 8'h3C};

        // Reset for one cycle, then line must stay idle for 20 bit times.
        rx  = 1'b1;
        rst = 1'b0;
        #5 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_tx_high", tx, 1);
        count_lows(20 * CPB, lows);
        check("reset_idle_no_toggle", lows, 0);
        check("reset_no_frames", got_q.size(), 0);

        // Single echo with start-edge latency. Expected: stop sample at
        // 2 + HALF + 9*CPB (+-1) after the pin edge, then 2 more cycles.
        @(negedge clk);
        c0 = cyc;
        send_frame(8'h53, 1'b1, BIT_NS);
        exp_q.push_back(8'h53);
        check_echoes("single");
        if (last_q.size() > 0) begin
            w = int'(last_q[0].start - c0);
            check("single_echo_latency",
                  (w >= HALF + 9 * CPB + 3) && (w <= HALF + 9 * CPB + 5), 1);
        end

        // Data patterns separated by 700..1000 ns gaps.
        foreach (patterns[i]) begin
            send_frame(patterns[i], 1'b1, BIT_NS);
            exp_q.push_back(patterns[i]);
            #($urandom_range(1000, 700));
        end
        check_echoes("patterns");

        // Back-to-back frames: echoes must start exactly one frame apart.
        @(negedge clk);
        foreach (b2b[i]) begin
            send_frame(b2b[i], 1'b1, BIT_NS);
            exp_q.push_back(b2b[i]);
        end
        check_echoes("b2b");
        if (last_q.size() == 3) begin
            check("b2b_contiguous_1", last_q[1].start - last_q[0].start, 10 * CPB);
            check("b2b_contiguous_2", last_q[2].start - last_q[1].start, 10 * CPB);
        end

        // Error rejection: short glitch, bad stop bit, then a good frame.
        rx = 1'b0;
        #(BIT_NS / 4);
        rx = 1'b1;
        check_echoes("glitch");
        send_frame(8'h55, 1'b0, BIT_NS);
        check_echoes("framing_error");
        send_frame(8'h12, 1'b1, BIT_NS);
        exp_q.push_back(8'h12);
        check_echoes("after_error");

        // Reset in the middle of echoing 0xC3, while a 0 data bit is out.
        send_frame(8'hC3, 1'b1, BIT_NS);
        w = 0;
        while (tx !== 1'b0 && w < 15 * CPB) begin
            @(negedge clk);
            w++;
        end
        check("c3_echo_started", tx, 0);
        wait_cycles(3 * CPB + HALF);
        check("c3_low_before_reset", tx, 0);
        #7 rst = 1'b1;
        #1 check("reset_async_tx_high", tx, 1);
        @(negedge clk);
        @(posedge clk);
        #5 rst = 1'b0;
        count_lows(20 * CPB, lows);
        check("after_reset_quiet", lows, 0);
        check("after_reset_no_frames", got_q.size(), 0);
        got_q.delete();
        send_frame(8'h7E, 1'b1, BIT_NS);
        exp_q.push_back(8'h7E);
        check_echoes("after_reset");

        // Random bytes at -3%/0/+3% bit rate, some with a bad stop bit.
        for (int i = 0; i < 8; i++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(3, 0) != 0);
            case ($urandom_range(2, 0))
                0:       bit_ns = BIT_NS * 0.97;
                1:       bit_ns = BIT_NS * 1.03;
                default: bit_ns = BIT_NS;
            endcase
            if (!stop_ok) bit_ns = BIT_NS;
            send_frame(d, stop_ok, bit_ns);
            if (stop_ok) exp_q.push_back(d);
            #(BIT_NS * $urandom_range(3, 1) + $urandom_range(300, 0));
        end
        check_echoes("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
